// File: rtl/pixel_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_tx_pkg
//  Purpose  : Shared types and constants for the pixel-to-UART byte buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package pixel_tx_pkg;

    localparam int unsigned c_BYTE_W           = 8;
    localparam int unsigned c_BUSY_TIMEOUT_DEF = 15;
    localparam int unsigned c_TIMER_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_t;

endpackage : pixel_tx_pkg
`default_nettype wire

// File: rtl/pixel_tx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_tx_fifo_if
//  Purpose  : Pixel input / UART handshake bundle. ovf_count is present only
//             when PIXEL_TX_FIFO_OVF_CNT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
interface pixel_tx_fifo_if
    import pixel_tx_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
);
    logic                  in_valid;
    logic [c_BYTE_W-1:0]   in_data;
    logic                  busy_tx;
    logic                  transmit;
    logic [c_BYTE_W-1:0]   data_tx;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;
`ifdef PIXEL_TX_FIFO_OVF_CNT_EN
    logic [7:0]            ovf_count;

    modport master (
        output in_valid, in_data, busy_tx,
        input  transmit, data_tx, full, empty, level, overflow, ovf_count
    );
    modport slave (
        input  in_valid, in_data, busy_tx,
        output transmit, data_tx, full, empty, level, overflow, ovf_count
    );
`else
    modport master (
        output in_valid, in_data, busy_tx,
        input  transmit, data_tx, full, empty, level, overflow
    );
    modport slave (
        input  in_valid, in_data, busy_tx,
        output transmit, data_tx, full, empty, level, overflow
    );
`endif

endinterface : pixel_tx_fifo_if
`default_nettype wire

// File: rtl/pixel_tx_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with registered level, full and empty.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo
    import pixel_tx_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = c_BYTE_W
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  i_push,
    input  wire logic [WIDTH-1:0]      i_data,
    input  wire logic                  i_pop,
    output logic      [WIDTH-1:0]      o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic      [DEPTH_LOG2:0]   o_level
);

    localparam int                  c_DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL_LEVEL = (DEPTH_LOG2+1)'(c_DEPTH);

    logic [WIDTH-1:0]      r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_full;
    logic                  r_empty;

    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic [DEPTH_LOG2:0]   w_level_nxt;

    assign w_push_ok = i_push & ~r_full;
    assign w_pop_ok  = i_pop  & ~r_empty;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == c_FULL_LEVEL);
            r_empty <= (w_level_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_level = r_level;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/pixel_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_tx_fifo
//  Purpose  : Buffers pixel bytes and feeds them to a UART via transmit/busy.
//             Define PIXEL_TX_FIFO_OVF_CNT_EN to add the dropped-byte counter.
//  Revision : 1.0 - initial release
// ============================================================================
module pixel_tx_fifo
    import pixel_tx_pkg::*;
#(
    parameter int DEPTH_LOG2   = 4,
    parameter int BUSY_TIMEOUT = c_BUSY_TIMEOUT_DEF
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    pixel_tx_fifo_if.slave     io_bus
);

    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(BUSY_TIMEOUT - 1);

    tx_state_t              r_state;
    logic                   r_transmit;
    logic [c_BYTE_W-1:0]    r_data_tx;
    logic [c_TIMER_W-1:0]   r_timer;
    logic                   r_overflow;

    logic                   w_push;
    logic                   w_drop;
    logic                   w_pop;
    logic [c_BYTE_W-1:0]    w_head;
    logic                   w_full;
    logic                   w_empty;
    logic [DEPTH_LOG2:0]    w_level;

    // Full is the registered flag, so a push racing a pop while full is dropped.
    assign w_push = io_bus.in_valid & ~w_full;
    assign w_drop = io_bus.in_valid &  w_full;
    assign w_pop  = (r_state == ST_IDLE) & ~w_empty & ~io_bus.busy_tx;

    sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (c_BYTE_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (io_bus.in_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_transmit <= 1'b0;
            r_data_tx  <= '0;
            r_timer    <= '0;
        end else begin
            r_transmit <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_data_tx  <= w_head;
                        r_transmit <= 1'b1;
                        r_state    <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_timer <= '0;
                    r_state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    // A UART that never acknowledges must not stall the queue.
                    if (io_bus.busy_tx) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_timer == c_TIMER_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!io_bus.busy_tx) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef PIXEL_TX_FIFO_OVF_CNT_EN
    logic [7:0] r_ovf_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_count <= '0;
        end else if (w_drop && (r_ovf_count != 8'hFF)) begin
            r_ovf_count <= r_ovf_count + 8'd1;
        end
    end

    assign io_bus.ovf_count = r_ovf_count;
`endif

    assign io_bus.transmit = r_transmit;
    assign io_bus.data_tx  = r_data_tx;
    assign io_bus.full     = w_full;
    assign io_bus.empty    = w_empty;
    assign io_bus.level    = w_level;
    assign io_bus.overflow = r_overflow;

endmodule : pixel_tx_fifo
`default_nettype wire
